decoder_stage_controller: RTL
=============================

Name: decoder_stage_controller

Overview:
- Central sequencer that drives global_stage to every processing unit in the single-FPGA decoder array.
- Per syndrome round it steps the array through measurement load, repeated grow/merge iterations and peeling.
- It watches the OR-reduced PE busy and odd vectors to decide when each stage has converged, and hands the result off over a valid/ack handshake.

Parameters:
- PU_COUNT, 64, number of processing units whose busy/odd bits are reduced.
- MAX_ITER, 31, maximum grow/merge iterations before abort.
- ITER_WIDTH, 5, width of the iteration counter; must hold MAX_ITER.
- GROW_HOLD, 2, cycles STAGE_GROW is held (≥1).
- SETTLE_CYCLES, 3, consecutive not-busy cycles that declare MERGE or PEELING converged (≥3, covers the PE stage register, busy register and reduction).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to decode one round; accepted only when ready=1.
- ready  out  1  controller idle and able to accept start.
- pu_busy  in  PU_COUNT  per-PE busy.
- pu_odd  in  PU_COUNT  per-PE odd flag.
- global_stage  out  STAGE_WIDTH  stage broadcast to all PEs (registered).
- iteration  out  ITER_WIDTH  grow/merge iterations completed this round.
- result_valid  out  1  peeling finished; neighbor_is_error outputs of the array are stable.
- result_ack  in  1  consumer has captured the result.
- timeout  out  1  round aborted because MAX_ITER was reached; valid with result_valid.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, global_stage=STAGE_IDLE, ready=1, iteration=0, result_valid=0, timeout=0, all counters 0.
- Reset asserted mid-operation returns to these values immediately; the PEs follow on their next clock.
- Every state is held in a register; global_stage equals the encoding of the current state.
- IDLE: ready=1. start=1 → PREP, with ready=0 in the next cycle.
- PREP (STAGE_MEASUREMENT_PREPARING): held 1 cycle → LOAD.
- LOAD (STAGE_MEASUREMENT_LOADING): held 1 cycle → GROW. iteration cleared to 0.
- GROW (STAGE_GROW): held GROW_HOLD cycles, then → MERGE.
- MERGE (STAGE_MERGE):
  - settle counter is 0 on entry; it clears on any cycle with |pu_busy=1 and increments otherwise.
  - The first 2 cycles after entry are ignored regardless of pu_busy, because PE busy is stale.
  - Exit when the counter reaches SETTLE_CYCLES. On exit, iteration increments by 1, saturating at MAX_ITER.
  - Exit decision, using the incremented iteration value:
    - |pu_odd=0 → PEEL.
    - |pu_odd=1 and iteration<MAX_ITER → GROW.
    - |pu_odd=1 and iteration==MAX_ITER → DONE with timeout=1.
- PEEL (STAGE_PEELING): same settle rule as MERGE. On exit → DONE.
- DONE (STAGE_IDLE broadcast, so PEs freeze error outputs):
  - result_valid=1 from the cycle of entry.
  - result_ack=1 while result_valid=1 → IDLE next cycle; result_valid and timeout drop to 0 and ready rises to 1.
  - result_ack while not in DONE is ignored.
  - start while not in IDLE is ignored; there is no queueing.
- start and result_ack high in the same DONE cycle: ack is honoured. start is ignored because ready=0 in that cycle.
- iteration holds its value through DONE and clears on the next LOAD.

Optional Feature:
- Macro DECODER_ERASURE_EN.
- Defined:
  - adds input erasure_present (1 bit), sampled with start.
  - If erasure_present=1, an ERASE state (STAGE_ERASURE_LOADING) is inserted for 1 cycle between LOAD and the first GROW, followed by one MERGE settle before the first GROW.
  - That merge does not increment iteration.
- Undefined:
  - the port is absent.
  - ERASE is never entered; LOAD → GROW directly.

Decomposition:
- Shared package (parameters.sv, already included by the PEs):
  - STAGE_WIDTH.
  - The STAGE_* encodings: IDLE, MEASUREMENT_PREPARING, MEASUREMENT_LOADING, ERASURE_LOADING, GROW, MERGE, PEELING.
  - Controller state enum aliasing these encodings.
- Sub-module convergence_detector:
  - inputs: clear, any_busy.
  - output: settled.
  - contains the 2-cycle blanking and the SETTLE_CYCLES counter; instantiated once and shared by MERGE and PEEL.

Test Plan:
- Empty syndrome (pu_odd=0, pu_busy=0):
  - start → stages PREP, LOAD, GROW×2, MERGE×5, PEEL×5, DONE.
  - iteration=1, timeout=0, result_valid 15 cycles after start.
- Two-iteration round:
  - pu_odd=1 through the first merge, then 0; pu_busy pulsed 4 cycles each merge.
  - Sequence is GROW→MERGE→GROW→MERGE→PEEL; iteration=2.
  - Each merge lasts 2+4+3 cycles when busy starts on merge cycle 3.
- Timeout with MAX_ITER=3 and pu_odd stuck 1:
  - exactly 3 MERGE visits, then DONE with timeout=1 and iteration=3.
- Handshake:
  - start while in GROW is ignored.
  - Ack held low for 10 cycles keeps DONE and result_valid=1.
  - Ack pulse → IDLE and ready=1 next cycle.
  - A new start then decodes with iteration cleared.
- Reset mid-PEEL: reset_n low asynchronously → global_stage=STAGE_IDLE, ready=1, result_valid=0 before the next clk edge.
- DECODER_ERASURE_EN build:
  - erasure_present=1 → LOAD, ERASE, MERGE, GROW…, and iteration counts only post-grow merges.
  - erasure_present=0 → identical to the non-erasure build.

Source files
------------

// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encodings and controller state type for the decoder array.
// The controller state enum aliases the broadcast stage encodings so that the
// state register maps directly onto global_stage (DONE broadcasts STAGE_IDLE).
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING       = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd6;

  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE  = STAGE_IDLE,
    ST_PREP  = STAGE_MEASUREMENT_PREPARING,
    ST_LOAD  = STAGE_MEASUREMENT_LOADING,
    ST_ERASE = STAGE_ERASURE_LOADING,
    ST_GROW  = STAGE_GROW,
    ST_MERGE = STAGE_MERGE,
    ST_PEEL  = STAGE_PEELING,
    ST_DONE  = 3'd7
  } ctrl_state_e;

  // DONE freezes the PEs, so it is broadcast as IDLE.
  function automatic logic [STAGE_WIDTH-1:0] stage_of(input ctrl_state_e s);
    logic [STAGE_WIDTH-1:0] st;
    st = s;
    if (s == ST_DONE) st = STAGE_IDLE;
    return st;
  endfunction

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Handshake, status and PE reduction bundle of the stage controller.
// With DECODER_ERASURE_EN defined, erasure_present is added (sampled with start).
interface decoder_stage_controller_if #(
  parameter int PU_COUNT   = 64,
  parameter int ITER_WIDTH = 5
);
  import decoder_stage_controller_pkg::*;

  logic                   start;
  logic                   ready;
  logic [PU_COUNT-1:0]    pu_busy;
  logic [PU_COUNT-1:0]    pu_odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic [ITER_WIDTH-1:0]  iteration;
  logic                   result_valid;
  logic                   result_ack;
  logic                   timeout;
`ifdef DECODER_ERASURE_EN
  logic                   erasure_present;

  modport master (
    output start, pu_busy, pu_odd, result_ack, erasure_present,
    input  ready, global_stage, iteration, result_valid, timeout
  );
  modport slave (
    input  start, pu_busy, pu_odd, result_ack, erasure_present,
    output ready, global_stage, iteration, result_valid, timeout
  );
`else
  modport master (
    output start, pu_busy, pu_odd, result_ack,
    input  ready, global_stage, iteration, result_valid, timeout
  );
  modport slave (
    input  start, pu_busy, pu_odd, result_ack,
    output ready, global_stage, iteration, result_valid, timeout
  );
`endif

endinterface

// File: rtl/decoder_stage_controller_convergence_detector.sv
// Convergence detector shared by MERGE and PEEL: after clear it blanks two
// cycles (PE busy is stale), then counts consecutive not-busy cycles and
// flags settled on the cycle that completes SETTLE_CYCLES of them.
module convergence_detector #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic any_busy,
  output logic settled
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]    blank_reg;
  logic [CW-1:0] cnt_reg;

  // Blanking counter then consecutive-idle counter; busy restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_reg <= 2'd0;
      cnt_reg   <= '0;
    end else if (clear) begin
      blank_reg <= 2'd0;
      cnt_reg   <= '0;
    end else if (blank_reg != 2'd2) begin
      blank_reg <= blank_reg + 2'd1;
    end else if (any_busy) begin
      cnt_reg   <= '0;
    end else begin
      cnt_reg   <= cnt_reg + CW'(1);
    end
  end

  // Settled is independent of clear, so the parent may clear on settled.
  always_comb begin
    settled = (blank_reg == 2'd2) && !any_busy && (cnt_reg == CW'(SETTLE_CYCLES - 1));
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Stage sequencer for the decoder array: PREP, LOAD, [ERASE, MERGE,]
// GROW/MERGE iterations, PEEL, then DONE with a valid/ack result handoff.
// DECODER_ERASURE_EN enables the erasure-loading stage.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int MAX_ITER      = 31,
  parameter int ITER_WIDTH    = 5,
  parameter int GROW_HOLD     = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input logic                       clk,
  input logic                       reset_n,
  decoder_stage_controller_if.slave bus
);

  localparam int GW = (GROW_HOLD > 1) ? $clog2(GROW_HOLD) : 1;

  ctrl_state_e            state_reg, state_next;
  logic [STAGE_WIDTH-1:0] stage_reg;
  logic [ITER_WIDTH-1:0]  iter_reg, iter_next, iter_inc;
  logic                   timeout_reg, timeout_next;
  logic [GW-1:0]          grow_cnt_reg, grow_cnt_next;
  logic                   erase_sel_reg, erase_sel_next;
  logic                   erase_merge_reg, erase_merge_next;
  logic [PU_COUNT-1:0]    busy_vec, odd_vec;
  logic                   any_busy, any_odd, erase_req;
  logic                   settled, det_clear;

  assign busy_vec = bus.pu_busy;
  assign odd_vec  = bus.pu_odd;
  assign any_busy = |busy_vec;
  assign any_odd  = |odd_vec;

`ifdef DECODER_ERASURE_EN
  assign erase_req = bus.erasure_present;
`else
  assign erase_req = 1'b0;
`endif

  // Detector runs only inside MERGE/PEEL and restarts on every exit.
  assign det_clear = !((state_reg == ST_MERGE) || (state_reg == ST_PEEL)) || settled;

  convergence_detector #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_detector (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (det_clear),
    .any_busy (any_busy),
    .settled  (settled)
  );

  assign iter_inc = (iter_reg == ITER_WIDTH'(MAX_ITER)) ? iter_reg : iter_reg + ITER_WIDTH'(1);

  // State, broadcast stage and round bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      stage_reg       <= STAGE_IDLE;
      iter_reg        <= '0;
      timeout_reg     <= 1'b0;
      grow_cnt_reg    <= '0;
      erase_sel_reg   <= 1'b0;
      erase_merge_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stage_reg       <= stage_of(state_next);
      iter_reg        <= iter_next;
      timeout_reg     <= timeout_next;
      grow_cnt_reg    <= grow_cnt_next;
      erase_sel_reg   <= erase_sel_next;
      erase_merge_reg <= erase_merge_next;
    end
  end

  // Next-state and bookkeeping decisions.
  always_comb begin
    state_next       = state_reg;
    iter_next        = iter_reg;
    timeout_next     = timeout_reg;
    grow_cnt_next    = '0;
    erase_sel_next   = erase_sel_reg;
    erase_merge_next = erase_merge_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next     = ST_PREP;
          erase_sel_next = erase_req;
          timeout_next   = 1'b0;
        end
      end
      ST_PREP: state_next = ST_LOAD;
      ST_LOAD: begin
        iter_next  = '0;
        state_next = erase_sel_reg ? ST_ERASE : ST_GROW;
      end
      ST_ERASE: begin
        state_next       = ST_MERGE;
        erase_merge_next = 1'b1;
      end
      ST_GROW: begin
        if (grow_cnt_reg == GW'(GROW_HOLD - 1)) state_next = ST_MERGE;
        else grow_cnt_next = grow_cnt_reg + GW'(1);
      end
      ST_MERGE: begin
        if (settled) begin
          if (erase_merge_reg) begin
            // The erasure merge precedes the first grow and is not an iteration.
            erase_merge_next = 1'b0;
            state_next       = ST_GROW;
          end else begin
            iter_next = iter_inc;
            if (!any_odd) begin
              state_next = ST_PEEL;
            end else if (iter_inc == ITER_WIDTH'(MAX_ITER)) begin
              state_next   = ST_DONE;
              timeout_next = 1'b1;
            end else begin
              state_next = ST_GROW;
            end
          end
        end
      end
      ST_PEEL: if (settled) state_next = ST_DONE;
      ST_DONE: begin
        if (bus.result_ack) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.ready        = (state_reg == ST_IDLE);
    bus.result_valid = (state_reg == ST_DONE);
    bus.global_stage = stage_reg;
    bus.iteration    = iter_reg;
    bus.timeout      = timeout_reg;
  end

endmodule
